// File: rtl/baopoco_adc_power_acc.sv
// ADC power accumulator: squares each parallel sample word and sums the squares over a
// window of 2^L valid words, publishing a saturated 32-bit total at each window end.
module baopoco_adc_power_acc #(
   parameter int unsigned SAMPLE_WIDTH = 8,
   parameter int unsigned NUM_SAMPLES  = 4,
   parameter int unsigned MAX_LEN_LOG2 = 16
) (
   input  logic                                 user_clk,
   input  logic                                 user_rst,
   input  logic [SAMPLE_WIDTH*NUM_SAMPLES-1:0]  adc_data,
   input  logic                                 adc_valid,
   input  logic                                 sync_in,
   input  logic [4:0]                           acc_len_log2,
   output logic [31:0]                          sum_sq,
   output logic                                 sum_sq_sat,
   output logic                                 dump_valid,
   output logic [15:0]                          dump_count
);

   localparam int unsigned DataW = SAMPLE_WIDTH * NUM_SAMPLES;
   localparam int unsigned SqW   = 2 * SAMPLE_WIDTH - 1;
   localparam int unsigned SumW  = SqW + $clog2(NUM_SAMPLES);
   localparam int unsigned AccW  = SumW + MAX_LEN_LOG2;
   localparam int unsigned CntW  = MAX_LEN_LOG2 + 1;
   localparam logic [4:0]  MaxLen = 5'(MAX_LEN_LOG2);

   // S1
   logic [DataW-1:0] data_q;
   logic             v1_q;
   // S2
   logic [SqW-1:0]   sq_d [NUM_SAMPLES];
   logic [SqW-1:0]   sq_q [NUM_SAMPLES];
   logic             v2_q;
   // S3
   logic [SumW-1:0]  sum_d;
   logic [SumW-1:0]  sum_q;
   logic             v3_q;
   // S4
   logic [AccW-1:0]  acc_q;
   logic [CntW-1:0]  cnt_q;
   logic [4:0]       len_q;

   logic [4:0]       len_start;
   logic [4:0]       len_cur;
   logic [CntW-1:0]  last_cnt;
   logic [AccW-1:0]  acc_sum;
   logic             at_last;
   logic             acc_sat;

   // Sign-extend before squaring so the low SqW bits of the product are exact.
   for (genvar g = 0; g < NUM_SAMPLES; g++) begin : g_sq
      logic signed [SqW-1:0] smp;
      assign smp     = SqW'($signed(data_q[g*SAMPLE_WIDTH +: SAMPLE_WIDTH]));
      assign sq_d[g] = smp * smp;
   end

   always_comb begin
      sum_d = '0;
      for (int i = 0; i < NUM_SAMPLES; i++) begin
         sum_d = sum_d + SumW'(sq_q[i]);
      end
   end

   // Window length is taken fresh only when a window starts; otherwise the latched value.
   always_comb begin
      len_start = (acc_len_log2 > MaxLen) ? MaxLen : acc_len_log2;
      len_cur   = (cnt_q == '0) ? len_start : len_q;
      last_cnt  = (CntW'(1) << len_cur) - CntW'(1);
      acc_sum   = acc_q + AccW'(sum_q);
      at_last   = (cnt_q == last_cnt);
      acc_sat   = |acc_sum[AccW-1:32];
   end

   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         data_q     <= '0;
         v1_q       <= 1'b0;
         for (int i = 0; i < NUM_SAMPLES; i++) sq_q[i] <= '0;
         v2_q       <= 1'b0;
         sum_q      <= '0;
         v3_q       <= 1'b0;
         acc_q      <= '0;
         cnt_q      <= '0;
         len_q      <= '0;
         sum_sq     <= '0;
         sum_sq_sat <= 1'b0;
         dump_valid <= 1'b0;
         dump_count <= '0;
      end else begin
         data_q     <= adc_data;
         v1_q       <= adc_valid;
         sq_q       <= sq_d;
         v2_q       <= v1_q & ~sync_in;
         sum_q      <= sum_d;
         v3_q       <= v2_q & ~sync_in;
         dump_valid <= 1'b0;
         if (sync_in) begin
            acc_q <= '0;
            cnt_q <= '0;
         end else if (v3_q) begin
            if (cnt_q == '0) len_q <= len_start;
            if (at_last) begin
               sum_sq     <= acc_sat ? 32'hFFFF_FFFF : acc_sum[31:0];
               sum_sq_sat <= acc_sat;
               dump_valid <= 1'b1;
               dump_count <= dump_count + 16'd1;
               acc_q      <= '0;
               cnt_q      <= '0;
            end else begin
               acc_q <= acc_sum;
               cnt_q <= cnt_q + CntW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_baopoco_adc_power_acc.sv
// Scoreboard bench for baopoco_adc_power_acc: a behavioural window model pushes expected
// dumps when words are driven; a negedge monitor pops and checks them cycle by cycle.
module tb_baopoco_adc_power_acc;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] adc_data;
   logic        adc_valid;
   logic        sync_in;
   logic [4:0]  acc_len_log2;
   logic [31:0] sum_sq;
   logic        sum_sq_sat;
   logic        dump_valid;
   logic [15:0] dump_count;

   baopoco_adc_power_acc dut (
      .user_clk     (clk),
      .user_rst     (rst),
      .adc_data     (adc_data),
      .adc_valid    (adc_valid),
      .sync_in      (sync_in),
      .acc_len_log2 (acc_len_log2),
      .sum_sq       (sum_sq),
      .sum_sq_sat   (sum_sq_sat),
      .dump_valid   (dump_valid),
      .dump_count   (dump_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   typedef struct {
      logic [31:0] sum;
      logic        sat;
      int          at_cyc;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      logic   v;
      longint p;
   } pw_t;
   pw_t    pipe[3];
   longint m_acc = 0;
   int     m_cnt = 0;
   int     m_len = 0;

   function automatic longint power(input logic [31:0] d);
      longint t;
      logic signed [7:0] b;
      t = 0;
      for (int i = 0; i < 4; i++) begin
         b = d[i*8 +: 8];
         t += longint'(b) * longint'(b);
      end
      return t;
   endfunction

   // Drive one clock's inputs and advance the model by the edge that consumes them.
   // A word reaches the accumulator three edges after the edge that captures it.
   task automatic step(input logic [31:0] d, input logic v, input logic s);
      exp_t e;
      adc_data  = d;
      adc_valid = v;
      sync_in   = s;
      if (s) begin
         for (int i = 0; i < 3; i++) pipe[i].v = 1'b0;
         m_acc = 0;
         m_cnt = 0;
      end else if (pipe[0].v) begin
         if (m_cnt == 0) m_len = (acc_len_log2 > 5'd16) ? 16 : int'(acc_len_log2);
         m_acc += pipe[0].p;
         if (m_cnt == (1 << m_len) - 1) begin
            e.sat    = (m_acc > 64'hFFFF_FFFF);
            e.sum    = e.sat ? 32'hFFFF_FFFF : m_acc[31:0];
            e.at_cyc = cyc + 1;
            exp_q.push_back(e);
            m_acc = 0;
            m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end
      pipe[0] = pipe[1];
      pipe[1] = pipe[2];
      pipe[2].v = v;
      pipe[2].p = power(d);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step($urandom, 1'b0, 1'b0);
   endtask

   task automatic words(input logic [31:0] d, input int n);
      repeat (n) step(d, 1'b1, 1'b0);
   endtask

   logic [31:0] hold_sum;
   logic        hold_sat;
   logic [15:0] exp_cnt;
   exp_t        got;

   always @(negedge clk) begin
      if (rst) begin
         hold_sum = '0;
         hold_sat = 1'b0;
         exp_cnt  = '0;
      end else if (exp_q.size() > 0 && exp_q[0].at_cyc == cyc) begin
         got = exp_q.pop_front();
         exp_cnt++;
         check("dump_valid", dump_valid, 1'b1);
         check("sum_sq", sum_sq, got.sum);
         check("sum_sq_sat", sum_sq_sat, got.sat);
         check("dump_count", dump_count, exp_cnt);
         hold_sum = got.sum;
         hold_sat = got.sat;
      end else begin
         check("no_dump", dump_valid, 1'b0);
         check("sum_hold", sum_sq, hold_sum);
         check("sat_hold", sum_sq_sat, hold_sat);
         check("count_hold", dump_count, exp_cnt);
      end
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         pipe[i].v = 1'b0;
         pipe[i].p = 0;
      end
      rst          = 1'b1;
      adc_data     = '0;
      adc_valid    = 1'b0;
      sync_in      = 1'b0;
      acc_len_log2 = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_sum", sum_sq, 32'h0);
      check("rst_sat", sum_sq_sat, 1'b0);
      check("rst_dv", dump_valid, 1'b0);
      check("rst_cnt", dump_count, 16'h0);
      rst = 1'b0;
      idle(2);

      // Basic window: 4 x 0x7F -> 0x0003F010
      acc_len_log2 = 5'd2;
      words(32'h7F7F_7F7F, 4);
      idle(4);

      // Mixed signs with invalid cycles interleaved -> 0x50
      acc_len_log2 = 5'd3;
      repeat (8) begin
         step(32'hFE02_FF01, 1'b1, 1'b0);
         idle(1);
      end
      idle(4);

      // L=0: back-to-back single-word windows
      acc_len_log2 = 5'd0;
      step(32'h1010_1010, 1'b1, 1'b0);
      step(32'h2020_2020, 1'b1, 1'b0);
      idle(4);

      // Clamped L=31 saturating window; mid-window L change must not matter
      acc_len_log2 = 5'd31;
      words(32'h8080_8080, 10);
      acc_len_log2 = 5'd1;
      words(32'h8080_8080, 65536 - 10);
      words(32'h0000_0000, 2);
      idle(4);

      // Sync mid-window, then a clean window of 0x01 -> 0x10
      acc_len_log2 = 5'd2;
      words(32'h7F7F_7F7F, 3);
      step(32'h0, 1'b0, 1'b1);
      words(32'h0101_0101, 4);
      idle(4);
      // Sync on the same edge the window's last word reaches the accumulator
      words(32'h0101_0101, 4);
      idle(2);
      step(32'h0, 1'b0, 1'b1);
      idle(4);
      // A valid word presented with sync opens the new window
      step(32'h0202_0202, 1'b1, 1'b1);
      words(32'h0101_0101, 3);
      idle(4);

      // Asynchronous reset between edges, mid-window
      acc_len_log2 = 5'd3;
      words(32'h7F7F_7F7F, 5);
      #2;
      rst = 1'b1;
      #1;
      check("arst_sum", sum_sq, 32'h0);
      check("arst_sat", sum_sq_sat, 1'b0);
      check("arst_dv", dump_valid, 1'b0);
      check("arst_cnt", dump_count, 16'h0);
      for (int i = 0; i < 3; i++) pipe[i].v = 1'b0;
      m_acc = 0;
      m_cnt = 0;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      acc_len_log2 = 5'd1;
      words(32'h0202_0202, 2);
      idle(6);

      check("drain", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/baopoco_adc_power_acc.md
# baopoco_adc_power_acc

ADC power accumulator for the baopoco ADC monitoring path. The block squares each parallel ADC sample and sums the squares over a software-programmable window of 2^N valid clocks. It holds the 32-bit window total on `sum_sq`, which drives `user_data_in` of the `adc_sum_sq2` software register; software reads ADC input power from that register. The block runs entirely in the `user_clk` domain.

## Interface
- `SAMPLE_WIDTH`, 8: bits per ADC sample, signed two's complement.
- `NUM_SAMPLES`, 4: samples presented in parallel per clock.
- `MAX_LEN_LOG2`, 16: largest accepted window exponent.

Ports:
- `user_clk`  in  1  block clock, rising edge.
- `user_rst`  in  1  asynchronous, active-high reset.
- `adc_data`  in  32  four samples; sample 0 in [7:0], sample 3 in [31:24].
- `adc_valid`  in  1  `adc_data` valid this cycle.
- `sync_in`  in  1  restart the window; in-flight partial sums are discarded.
- `acc_len_log2`  in  5  window exponent from a software register; the window is 2^L valid cycles.
- `sum_sq`  out  32  last completed window total, saturated; feeds the register's `user_data_in`.
- `sum_sq_sat`  out  1  high if that window saturated.
- `dump_valid`  out  1  one-cycle pulse when `sum_sq` updates.
- `dump_count`  out  16  number of completed windows; wraps at 0xFFFF to 0.

## Operation
- **Pipeline** (one sample word accepted per clock, valid bit carried through every stage):
  - S1: register `adc_data` and `adc_valid`.
  - S2: four signed squares, 15 bits unsigned each; max (-128)^2 = 16384.
  - S3: adder tree to 17 bits; max 65536.
  - S4: accumulate.
- **Accumulator**: 33 bits wide. Max window is 65536 × 2^16 = 2^32, one bit beyond 32.
- **Window length**: L is latched when a window starts, i.e. the first valid word into S4 with the window counter at 0. Values of L above MAX_LEN_LOG2 are clamped to 16. Changing `acc_len_log2` mid-window has no effect until the next window.
- **Window counter**: 17 bits; counts valid words entering S4. Words with `adc_valid` low are ignored at every stage and are not counted.
- **Last word of a window** (counter = 2^L−1):
  - `sum_sq` ← min(acc + sum, 0xFFFFFFFF).
  - `sum_sq_sat` ← (acc + sum > 0xFFFFFFFF).
  - `dump_valid` pulses; `dump_count` increments.
  - Accumulator and counter clear to 0.
- **L = 0**: every valid word is a complete window.
- **`sync_in` high** (sampled at an edge):
  - Clears the accumulator, the window counter, and the S2–S4 valid bits.
  - No dump occurs; `sum_sq` and `sum_sq_sat` hold their values.
  - The word presented with `sync_in` (if valid) is the first word of the new window.
- **`sync_in` on the same edge as a window's last word**: the sync wins; no dump.
- **Reset values**: `sum_sq` = 0, `sum_sq_sat` = 0, `dump_valid` = 0, `dump_count` = 0. Accumulator, counter and all pipeline valid bits are 0. Reset asserted mid-window discards all partial state immediately, without waiting for a clock.

## Timing
- **Latency**: a valid word presented at edge E0 reaches S4 at edge E3. If it is the last word of a window, `sum_sq` and `dump_valid` change at E3; `dump_valid` is high for exactly the cycle after E3.
- **Throughput**: one word per clock, with no back-pressure. The window boundary costs no dead cycle; the next window's first word accumulates at E4 from a cleared accumulator.
- **Output stability**: `sum_sq` is stable between dumps and changes only on a dump edge. The register samples it on `user_clk`, so there is no extra handshake.
- **Registered outputs**: all outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- **Basic window**: L=2; all samples 0x7F; `adc_valid` high for 4 cycles → one `dump_valid` 3 cycles after the last word; `sum_sq`=0x0003F010; `sum_sq_sat`=0; `dump_count`=1.
- **Mixed signs**: L=3; samples {0x01,0xFF,0x02,0xFE} for 8 valid words, with `adc_valid` low on every other cycle → `sum_sq`=0x00000050; the dump arrives 3 cycles after the 8th valid word, and invalid cycles are not counted.
- **Saturation**: L=16; all samples 0x80 for 65536 valid cycles → `sum_sq`=0xFFFFFFFF, `sum_sq_sat`=1. The next window of all 0x00 gives 0x00000000 with `sum_sq_sat`=0.
- **L=0 and clamp**: L=0; samples 0x10 then 0x20 on consecutive cycles → back-to-back dumps of 0x00000400 and 0x00001000. L=31 behaves exactly as L=16.
- **Sync**:
  - L=2; `sync_in` after 3 valid words → no dump, `sum_sq` unchanged.
  - 4 further valid words of 0x01 → `sum_sq`=0x00000010.
  - `sync_in` coincident with a window's last word → no dump.
- **Reset**: assert `user_rst` mid-window and between clock edges → all outputs 0 immediately. After release, a full L=1 window of 0x02 gives `sum_sq`=0x00000020 and `dump_count`=1.
